// File: rtl/core_mem_responder.sv
// -----------------------------------------------------------------------------
// core_mem_responder
//
// Memory-side responder for the core request/grant memory interface. One
// instance sits behind each core memory port (imem_* or dmem_*). A request is
// captured in IDLE, held for WAIT_CYCLES cycles plus any external stall, then
// a byte-strobed write or a full-word read is performed against an internal
// word array. The response (gnt/err/rdata) is registered and lasts one cycle.
//
// Optional feature macro: CORE_MEM_RESPONDER_ERR_EN
//   defined   : addresses outside [BASE_ADDR, BASE_ADDR + DEPTH*bytes) answer
//               with mem_err=1, mem_rdata=0 and never touch the array.
//   undefined : no range check; the word index wraps modulo DEPTH and
//               mem_err is always 0.
//
// Parameters
//   ADDR_W      request address width
//   DATA_W      data width (strobe width DATA_W/8)
//   DEPTH       number of DATA_W words, power of two
//   BASE_ADDR   byte address of word 0
//   WAIT_CYCLES fixed extra cycles between acceptance and grant (0..255)
//
// Ports
//   g_clk      in   clock, all state on rising edge
//   g_resetn   in   asynchronous active-low reset
//   mem_req    in   request valid, held by the requester until mem_gnt
//   mem_addr   in   byte address (sub-word bits ignored)
//   mem_wen    in   1 = write, 0 = read
//   mem_strb   in   write byte enables
//   mem_wdata  in   write data
//   mem_stall  in   back-pressure, holds off the grant while 1
//   mem_gnt    out  response valid for one cycle
//   mem_err    out  response error, qualified by mem_gnt
//   mem_rdata  out  read data, qualified by mem_gnt
// -----------------------------------------------------------------------------
module core_mem_responder #(
    parameter int unsigned          ADDR_W      = 64,
    parameter int unsigned          DATA_W      = 64,
    parameter int unsigned          DEPTH       = 1024,
    parameter logic [ADDR_W-1:0]    BASE_ADDR   = '0,
    parameter int unsigned          WAIT_CYCLES = 0
) (
    input  logic                    g_clk,
    input  logic                    g_resetn,
    input  logic                    mem_req,
    input  logic [ADDR_W-1:0]       mem_addr,
    input  logic                    mem_wen,
    input  logic [DATA_W/8-1:0]     mem_strb,
    input  logic [DATA_W-1:0]       mem_wdata,
    input  logic                    mem_stall,
    output logic                    mem_gnt,
    output logic                    mem_err,
    output logic [DATA_W-1:0]       mem_rdata
);

    localparam int STRB_W  = DATA_W / 8;
    localparam int BYTE_SH = (STRB_W > 1) ? $clog2(STRB_W) : 1;
    localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    // Captured request; every access works from these, never the live inputs.
    logic [ADDR_W-1:0]      r_addr;
    logic                   r_wen;
    logic [STRB_W-1:0]      r_strb;
    logic [DATA_W-1:0]      r_wdata;
    logic [7:0]             r_cnt;

    logic                   r_gnt;
    logic                   r_err;
    logic [DATA_W-1:0]      r_rdata;

    // Word storage: deliberately outside the reset domain so contents
    // survive g_resetn.
    logic [DATA_W-1:0]      r_mem [DEPTH];

    logic                   w_accept;
    logic                   w_commit;
    logic                   w_cnt_dec;
    logic                   w_oob;
    logic                   w_wr_en;
    logic [ADDR_W-1:0]      w_offset;
    logic [IDX_W-1:0]       w_idx;
    logic                   w_unused;

    // -------------------------------------------------------------------------
    // Address decode
    // -------------------------------------------------------------------------
    assign w_offset = r_addr - BASE_ADDR;
    assign w_idx    = w_offset[IDX_W+BYTE_SH-1:BYTE_SH];

`ifdef CORE_MEM_RESPONDER_ERR_EN
    // In range when at or above the base and the offset has no bits beyond
    // the array span (avoids forming BASE_ADDR + DEPTH*8, which could wrap).
    assign w_oob    = (r_addr < BASE_ADDR) ||
                      (w_offset[ADDR_W-1:IDX_W+BYTE_SH] != '0);
    assign w_unused = ^{w_offset[BYTE_SH-1:0]};
`else
    assign w_oob    = 1'b0;
    assign w_unused = ^{w_offset[ADDR_W-1:IDX_W+BYTE_SH], w_offset[BYTE_SH-1:0]};
`endif

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (mem_req) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                // The countdown runs even while stalled; stall only gates
                // the final step into RESP.
                if ((r_cnt == 8'd0) && !mem_stall) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: output / control decode
    // -------------------------------------------------------------------------
    always_comb begin
        w_accept  = 1'b0;
        w_commit  = 1'b0;
        w_cnt_dec = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_accept = mem_req;
            end
            S_WAIT: begin
                w_cnt_dec = (r_cnt != 8'd0);
                w_commit  = (r_cnt == 8'd0) && !mem_stall;
            end
            default: begin
                w_accept  = 1'b0;
            end
        endcase
    end

    // The array is written only on the WAIT->RESP edge. Since reset forces
    // the state to IDLE, a pending write is dropped if reset hits first.
    assign w_wr_en = w_commit && r_wen && !w_oob;

    // -------------------------------------------------------------------------
    // Request capture and wait counter
    // -------------------------------------------------------------------------
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_strb  <= '0;
            r_wdata <= '0;
            r_cnt   <= 8'd0;
        end else begin
            if (w_accept) begin
                r_addr  <= mem_addr;
                r_wen   <= mem_wen;
                r_strb  <= mem_strb;
                r_wdata <= mem_wdata;
                r_cnt   <= 8'(WAIT_CYCLES);
            end else if (w_cnt_dec) begin
                r_cnt   <= r_cnt - 8'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registered response. gnt/err/rdata are only non-zero during RESP, so
    // they fall back to zero on the following cycle.
    // -------------------------------------------------------------------------
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_gnt   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_gnt <= w_commit;
            if (w_commit) begin
                r_err   <= w_oob;
                r_rdata <= (!r_wen && !w_oob) ? r_mem[w_idx] : '0;
            end else begin
                r_err   <= 1'b0;
                r_rdata <= '0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Byte-strobed array write (no reset)
    // -------------------------------------------------------------------------
    always_ff @(posedge g_clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (r_strb[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= r_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign mem_gnt   = r_gnt;
    assign mem_err   = r_err;
    assign mem_rdata = r_rdata;

endmodule

// File: tb/tb_core_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_core_mem_responder
//
// Two responders share clock and reset: index 0 with WAIT_CYCLES=0 and
// index 1 with WAIT_CYCLES=3. Expected responses are queued when a request
// is driven and popped when mem_gnt is seen. Honours the optional
// CORE_MEM_RESPONDER_ERR_EN macro for the out-of-range expectations.
// -----------------------------------------------------------------------------
module tb_core_mem_responder;

`ifdef CORE_MEM_RESPONDER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic           g_clk;
    logic           g_resetn;

    logic           req_s   [2];
    logic [63:0]    addr_s  [2];
    logic           wen_s   [2];
    logic [7:0]     strb_s  [2];
    logic [63:0]    wdata_s [2];
    logic           stall_s [2];
    logic           gnt_s   [2];
    logic           err_s   [2];
    logic [63:0]    rdata_s [2];

    int checks;
    int errors;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb_q[$];

    typedef struct {
        logic        wen;
        logic [63:0] addr;
        logic [7:0]  strb;
        logic [63:0] wdata;
        logic [63:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[16];

    core_mem_responder #(
        .ADDR_W(64), .DATA_W(64), .DEPTH(1024),
        .BASE_ADDR(64'h0), .WAIT_CYCLES(0)
    ) u_dut0 (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .mem_req   (req_s[0]),
        .mem_addr  (addr_s[0]),
        .mem_wen   (wen_s[0]),
        .mem_strb  (strb_s[0]),
        .mem_wdata (wdata_s[0]),
        .mem_stall (stall_s[0]),
        .mem_gnt   (gnt_s[0]),
        .mem_err   (err_s[0]),
        .mem_rdata (rdata_s[0])
    );

    core_mem_responder #(
        .ADDR_W(64), .DATA_W(64), .DEPTH(1024),
        .BASE_ADDR(64'h0), .WAIT_CYCLES(3)
    ) u_dut3 (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .mem_req   (req_s[1]),
        .mem_addr  (addr_s[1]),
        .mem_wen   (wen_s[1]),
        .mem_strb  (strb_s[1]),
        .mem_wdata (wdata_s[1]),
        .mem_stall (stall_s[1]),
        .mem_gnt   (gnt_s[1]),
        .mem_err   (err_s[1]),
        .mem_rdata (rdata_s[1])
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // Drives one request at posedge+1 and waits for its grant. c counts
    // cycles from the one in which mem_req first goes high (cycle 0).
    // Stall is high in cycles [st_from, st_to). At cycle chg_at the request
    // inputs are scrambled and mem_req is dropped.
    task automatic run_txn(input int sel, input logic wen, input logic [63:0] addr,
                           input logic [7:0] strb, input logic [63:0] wdata,
                           input logic [63:0] exp_rd, input logic exp_err, input int exp_lat,
                           input int st_from, input int st_to, input int chg_at,
                           input string tag);
        exp_t e;
        exp_t got;
        bit   seen;
        int   c;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.lat   = exp_lat;
        sb_q.push_back(e);
        req_s[sel]   = 1'b1;
        wen_s[sel]   = wen;
        addr_s[sel]  = addr;
        strb_s[sel]  = strb;
        wdata_s[sel] = wdata;
        seen = 1'b0;
        c = 0;
        while (c < 64 && !seen) begin
            stall_s[sel] = (c >= st_from) && (c < st_to);
            if (c == chg_at) begin
                addr_s[sel]  = addr ^ 64'h8;
                wdata_s[sel] = ~wdata;
                strb_s[sel]  = ~strb;
                wen_s[sel]   = ~wen;
                req_s[sel]   = 1'b0;
            end
            @(negedge g_clk);
            if (gnt_s[sel]) begin
                seen = 1'b1;
                if (sb_q.size() == 0) begin
                    chk({tag, "_sb_empty"}, 64'd1, 64'd0);
                end else begin
                    got = sb_q.pop_front();
                    chk({tag, "_lat"},   64'(c),          64'(got.lat));
                    chk({tag, "_rdata"}, rdata_s[sel],    got.rdata);
                    chk({tag, "_err"},   64'(err_s[sel]), 64'(got.err));
                    $display("txn %-12s dut%0d wen=%0d addr=%h lat=%0d rdata=%h err=%0d",
                             tag, sel, wen, addr, c, rdata_s[sel], err_s[sel]);
                end
            end
            @(posedge g_clk);
            #1;
            c++;
        end
        req_s[sel]   = 1'b0;
        stall_s[sel] = 1'b0;
        if (!seen) begin
            chk({tag, "_timeout"}, 64'd0, 64'd1);
            void'(sb_q.pop_front());
        end
        // Response is one cycle wide and the data/err buses clear after it.
        @(negedge g_clk);
        chk({tag, "_gnt_off"}, 64'(gnt_s[sel]), 64'd0);
        chk({tag, "_rd_off"},  rdata_s[sel],    64'd0);
        chk({tag, "_err_off"}, 64'(err_s[sel]), 64'd0);
        @(posedge g_clk);
        #1;
    endtask

    initial begin
        int gcount;
        checks = 0;
        errors = 0;

        vecs[0]  = '{1'b1, 64'h10,   8'hFF, 64'h1122334455667788, 64'h0, 1'b0};
        vecs[1]  = '{1'b0, 64'h10,   8'h00, 64'h0, 64'h1122334455667788, 1'b0};
        vecs[2]  = '{1'b1, 64'h10,   8'h0F, 64'hAAAAAAAABBBBBBBB, 64'h0, 1'b0};
        vecs[3]  = '{1'b0, 64'h10,   8'h00, 64'h0, 64'h11223344BBBBBBBB, 1'b0};
        vecs[4]  = '{1'b1, 64'h10,   8'h00, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b0};
        vecs[5]  = '{1'b0, 64'h10,   8'h00, 64'h0, 64'h11223344BBBBBBBB, 1'b0};
        vecs[6]  = '{1'b1, 64'h00,   8'hFF, 64'h0123456789ABCDEF, 64'h0, 1'b0};
        vecs[7]  = '{1'b1, 64'h18,   8'hFF, 64'h0, 64'h0, 1'b0};
        vecs[8]  = '{1'b1, 64'h1F,   8'h81, 64'hDE000000000000AD, 64'h0, 1'b0};
        vecs[9]  = '{1'b0, 64'h18,   8'h00, 64'h0, 64'hDE000000000000AD, 1'b0};
        vecs[10] = '{1'b0, 64'h1C,   8'hFF, 64'h5555, 64'hDE000000000000AD, 1'b0};
        vecs[11] = '{1'b1, 64'h1FF8, 8'hFF, 64'h7777666655554444, 64'h0, 1'b0};
        vecs[12] = '{1'b0, 64'h1FF8, 8'h00, 64'h0, 64'h7777666655554444, 1'b0};
        vecs[13] = '{1'b1, 64'h2000, 8'hFF, 64'hCAFEF00DDEADBEEF, 64'h0, ERR_EN};
        vecs[14] = '{1'b0, 64'h00,   8'h00, 64'h0,
                     ERR_EN ? 64'h0123456789ABCDEF : 64'hCAFEF00DDEADBEEF, 1'b0};
        vecs[15] = '{1'b0, 64'h2000, 8'h00, 64'h0,
                     ERR_EN ? 64'h0 : 64'hCAFEF00DDEADBEEF, ERR_EN};

        for (int s = 0; s < 2; s++) begin
            req_s[s] = 1'b0; addr_s[s] = '0; wen_s[s] = 1'b0;
            strb_s[s] = '0; wdata_s[s] = '0; stall_s[s] = 1'b0;
        end
        g_resetn = 1'b0;
        repeat (3) @(posedge g_clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("reset_gnt",   64'(gnt_s[s]), 64'd0);
            chk("reset_err",   64'(err_s[s]), 64'd0);
            chk("reset_rdata", rdata_s[s],    64'd0);
        end
        g_resetn = 1'b1;
        @(posedge g_clk);
        #1;

        // Table vectors on the zero-wait responder.
        for (int i = 0; i < 16; i++) begin
            run_txn(0, vecs[i].wen, vecs[i].addr, vecs[i].strb, vecs[i].wdata,
                    vecs[i].exp_rd, vecs[i].exp_err, 2, -1, -1, -1, $sformatf("vec%0d", i));
        end

        // Inputs scrambled and mem_req dropped one cycle after acceptance.
        run_txn(0, 1'b1, 64'h28, 8'hFF, 64'h3333333333333333, 64'h0, 1'b0, 2, -1, -1, -1, "pre28");
        run_txn(0, 1'b1, 64'h20, 8'hFF, 64'h1111111111111111, 64'h0, 1'b0, 2, -1, -1, 1, "chg_wr");
        run_txn(0, 1'b0, 64'h20, 8'h00, 64'h0, 64'h1111111111111111, 1'b0, 2, -1, -1, -1, "chg_rd20");
        run_txn(0, 1'b0, 64'h28, 8'h00, 64'h0, 64'h3333333333333333, 1'b0, 2, -1, -1, -1, "chg_rd28");

        // WAIT_CYCLES=3: stall for the two cycles after the counter reaches 0.
        run_txn(1, 1'b1, 64'h40, 8'hFF, 64'h0F0E0D0C0B0A0908, 64'h0, 1'b0, 7, 4, 6, -1, "stall_wr");
        run_txn(1, 1'b0, 64'h40, 8'h00, 64'h0, 64'h0F0E0D0C0B0A0908, 1'b0, 5, -1, -1, -1, "w3_rd");
        // Stall asserted while still counting must not add latency.
        run_txn(1, 1'b0, 64'h40, 8'h00, 64'h0, 64'h0F0E0D0C0B0A0908, 1'b0, 5, 1, 4, -1, "early_stall");

        // Reset while a write is still waiting.
        run_txn(1, 1'b1, 64'h80, 8'hFF, 64'hEEEEEEEE00000001, 64'h0, 1'b0, 5, -1, -1, -1, "pre80");
        req_s[1] = 1'b1; wen_s[1] = 1'b1; addr_s[1] = 64'h80;
        strb_s[1] = 8'hFF; wdata_s[1] = 64'hFFFFFFFF00000002;
        repeat (2) begin
            @(posedge g_clk);
            #1;
        end
        g_resetn = 1'b0;
        #1;
        chk("rst_mid_gnt",   64'(gnt_s[1]), 64'd0);
        chk("rst_mid_err",   64'(err_s[1]), 64'd0);
        chk("rst_mid_rdata", rdata_s[1],    64'd0);
        req_s[1] = 1'b0;
        repeat (2) @(posedge g_clk);
        #1;
        g_resetn = 1'b1;
        gcount = 0;
        repeat (10) begin
            @(negedge g_clk);
            if (gnt_s[1]) gcount++;
        end
        chk("rst_no_gnt", 64'(gcount), 64'd0);
        @(posedge g_clk);
        #1;
        run_txn(1, 1'b0, 64'h80, 8'h00, 64'h0, 64'hEEEEEEEE00000001, 1'b0, 5, -1, -1, -1, "post_rst_rd");

        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
